// File: rtl/kim_mips_pkg.sv
// Shared definitions for the kim MIPS pipeline control blocks: operand forwarding
// encodings, the branch-hazard FSM state type and the hazard helper functions.
package kim_mips_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic {
        ST_RESOLVE = 1'b0,
        ST_STALL   = 1'b1
    } br_state_e;

    // Cycles a branch source must wait: an EX load needs two, an EX ALU result or a MEM load one.
    function automatic logic [1:0] src_need(input logic ex_hit, input logic ex_load,
                                            input logic mem_hit, input logic mem_load);
        logic [1:0] need;
        if (ex_hit && ex_load) begin
            need = 2'd2;
        end else if (ex_hit) begin
            need = 2'd1;
        end else if (mem_hit && mem_load) begin
            need = 2'd1;
        end else begin
            need = 2'd0;
        end
        return need;
    endfunction

    function automatic logic [1:0] need_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // The younger MEM result wins over WB; a MEM load has no data yet and cannot forward.
    function automatic logic [1:0] src_fwd(input logic mem_hit, input logic mem_load,
                                           input logic wb_hit);
        logic [1:0] sel;
        if (mem_hit && !mem_load) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/kim_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones once reached.
module kim_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_r;

    // Clear has priority; increments stop at the maximum value
    always_ff @(posedge clk) begin
        if (clear) begin
            count_r <= '0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/kim_branch_hazard_ctrl.sv
// ID-stage branch hazard controller: stalls until branch operands can be forwarded,
// selects forwarding sources, redirects/flushes on taken branches, counts events.
module kim_branch_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = kim_mips_pkg::REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ext_stall,
    input  logic                      id_is_branch,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      br_equal,
    input  logic                      ex_reg_write,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      mem_reg_write,
    input  logic                      mem_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      pc_write,
    output logic                      if_id_write,
    output logic                      if_id_flush,
    output logic                      id_ex_bubble,
    output logic                      pc_sel_branch,
    output logic [1:0]                fwd_a_sel,
    output logic [1:0]                fwd_b_sel,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      branch_cnt,
    output logic [CNT_WIDTH-1:0]      taken_cnt,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    import kim_mips_pkg::*;

    br_state_e state_r;
    logic      cnt_r;

    logic       ex_rs_s, ex_rt_s, mem_rs_s, mem_rt_s, wb_rs_s, wb_rt_s;
    logic [1:0] need_s;
    logic [1:0] fwd_a_s, fwd_b_s;
    logic       branch_inc_s, taken_inc_s, cnt_clear_s;

    function automatic logic reg_match(input logic we, input logic [REG_ADDR_WIDTH-1:0] rd,
                                       input logic [REG_ADDR_WIDTH-1:0] src);
        return we && (rd == src) && (rd != '0);
    endfunction

    assign ex_rs_s  = reg_match(ex_reg_write,  ex_rd,  id_rs);
    assign ex_rt_s  = reg_match(ex_reg_write,  ex_rd,  id_rt);
    assign mem_rs_s = reg_match(mem_reg_write, mem_rd, id_rs);
    assign mem_rt_s = reg_match(mem_reg_write, mem_rd, id_rt);
    assign wb_rs_s  = reg_match(wb_reg_write,  wb_rd,  id_rs);
    assign wb_rt_s  = reg_match(wb_reg_write,  wb_rd,  id_rt);

    assign need_s  = need_max(src_need(ex_rs_s, ex_mem_read, mem_rs_s, mem_mem_read),
                              src_need(ex_rt_s, ex_mem_read, mem_rt_s, mem_mem_read));
    assign fwd_a_s = src_fwd(mem_rs_s, mem_mem_read, wb_rs_s);
    assign fwd_b_s = src_fwd(mem_rt_s, mem_mem_read, wb_rt_s);

    // Pipeline control outputs decoded from the current state and the ID/EX/MEM/WB view
    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        pc_sel_branch = 1'b0;
        branch_inc_s  = 1'b0;
        taken_inc_s   = 1'b0;
        fwd_a_sel     = rst_n ? fwd_a_s : FWD_RF;
        fwd_b_sel     = rst_n ? fwd_b_s : FWD_RF;
        busy          = rst_n && (state_r == ST_STALL);
        if (rst_n && !ext_stall) begin
            case (state_r)
                ST_RESOLVE: begin
                    if (id_is_branch && (need_s != 2'd0)) begin
                        id_ex_bubble = 1'b1;
                    end else if (id_is_branch) begin
                        pc_write      = 1'b1;
                        if_id_write   = 1'b1;
                        pc_sel_branch = br_equal;
                        if_id_flush   = br_equal;
                        branch_inc_s  = 1'b1;
                        taken_inc_s   = br_equal;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                ST_STALL: begin
                    id_ex_bubble = 1'b1;
                end
                default: begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                end
            endcase
        end else begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end
    end

    // The RESOLVE cycle is the first bubble; STALL supplies the remaining need-1 bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RESOLVE;
            cnt_r   <= 1'b0;
        end else if (ext_stall) begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
        end else begin
            case (state_r)
                ST_RESOLVE: begin
                    if (id_is_branch && (need_s > 2'd1)) begin
                        state_r <= ST_STALL;
                        cnt_r   <= 1'b0;
                    end else begin
                        state_r <= ST_RESOLVE;
                        cnt_r   <= cnt_r;
                    end
                end
                ST_STALL: begin
                    if (cnt_r == 1'b0) begin
                        state_r <= ST_RESOLVE;
                        cnt_r   <= 1'b0;
                    end else begin
                        state_r <= ST_STALL;
                        cnt_r   <= cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_RESOLVE;
                    cnt_r   <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_clear_s = !rst_n;

    kim_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk   (clk),
        .clear (cnt_clear_s),
        .inc   (branch_inc_s),
        .count (branch_cnt)
    );

    kim_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_taken_cnt (
        .clk   (clk),
        .clear (cnt_clear_s),
        .inc   (taken_inc_s),
        .count (taken_cnt)
    );

    kim_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .clear (cnt_clear_s),
        .inc   (id_ex_bubble),
        .count (stall_cnt)
    );

endmodule
